// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word/register types for the pipeline, plus the
// memory-stage access state.
//   word_t     - 32-bit datapath word
//   regbits_t  - 5-bit register index
//   memstate_t - memory-stage access FSM state
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } memstate_t;

  localparam regbits_t LINK_REG = 5'd31;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-cache request/hit handshake.
//   dmemREN, dmemWEN     - read / write request
//   dmemaddr, dmemstore  - request address, store data
//   dhit                 - access complete
//   dmemload             - load data, valid with dhit
// master = memory stage, slave = data cache.
interface mem_stage_if;

  logic                 dmemREN;
  logic                 dmemWEN;
  cpu_types_pkg::word_t dmemaddr;
  cpu_types_pkg::word_t dmemstore;
  logic                 dhit;
  cpu_types_pkg::word_t dmemload;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );

endinterface

// File: rtl/llsc_link_reg.sv
// llsc_link_reg: load-linked reservation (valid + word address).
//   CLK, nRST   - clock, async active-low reset
//   set_link    - record addr as the linked word
//   clr_link    - drop the reservation (wins over set_link)
//   addr        - word address being set or checked
//   link_valid  - reservation held
//   link_hit    - reservation held and addr matches it
module llsc_link_reg (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        set_link,
  input  logic        clr_link,
  input  logic [29:0] addr,
  output logic        link_valid,
  output logic        link_hit
);

  logic [29:0] link_addr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (clr_link) begin
      link_valid <= 1'b0;
    end else if (set_link) begin
      link_valid <= 1'b1;
      link_addr  <= addr;
    end
  end

  assign link_hit = link_valid && (link_addr == addr);

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage pipeline. Issues the data-cache
// request for the EX/MEM instruction, stalls upstream while it is
// outstanding, buffers load data returning during a freeze, and holds
// the MEM/WB register.
//   CLK, nRST            - clock, async active-low reset
//   pipe_en              - global advance; MEM/WB loads only when high
//   exmem_*/control in   - EX/MEM latch contents (exmem_valid=0 is a bubble)
//   dbus                 - data-cache handshake (mem_stage_if.master)
//   mem_stall            - freeze PC .. EX/MEM
//   memwb_*              - MEM/WB register
//   halt                 - sticky halt, cleared only by reset
// Optional: MEM_LLSC_EN adds is_ll/is_sc/link_inv and an LL/SC link register.
//
// state | meaning
// IDLE  | no access pending; a new memop requests combinationally
// WAIT  | request held, waiting for dhit
// DONE  | access finished while frozen; result parked in ldbuf
module mem_stage
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     nRST,
  input  logic     pipe_en,
  input  logic     exmem_valid,
  input  word_t    aluOutport,
  input  word_t    rdat2,
  input  word_t    pcplus4,
  input  regbits_t rt,
  input  regbits_t rd,
  input  logic     MemToReg,
  input  logic     JType,
  input  logic     RegDst,
  input  logic     regWEN,
  input  logic     dMemREN,
  input  logic     dMemWEN,
  input  logic     Halt,
`ifdef MEM_LLSC_EN
  input  logic     is_ll,
  input  logic     is_sc,
  input  logic     link_inv,
`endif
  mem_stage_if.master dbus,
  output logic     mem_stall,
  output logic     memwb_valid,
  output logic     memwb_regWEN,
  output logic     memwb_halt,
  output regbits_t memwb_wsel,
  output word_t    memwb_wdat,
  output logic     halt
);

  memstate_t state, state_nxt;
  word_t     ldbuf;
  word_t     ld_data;
  word_t     wdat_nxt;
  regbits_t  wsel_nxt;
  logic      live;
  logic      memop;
  logic      req;
  logic      active_req;
  logic      load_en;

  // Once halted, everything reaching this stage is treated as a bubble.
  assign live  = exmem_valid && !halt;
  // nRST gating makes the request drop the moment reset asserts.
  assign memop = nRST && live && (dMemREN || dMemWEN);

`ifdef MEM_LLSC_EN
  logic link_valid;
  logic link_hit;
  logic sc_fail;
  logic set_link;
  logic clr_link;

  // A failing SC never reaches the cache.
  assign sc_fail = live && is_sc && !link_hit;
  assign req     = memop && !sc_fail;

  assign set_link = load_en && live && is_ll;
  assign clr_link = link_inv
                 || (load_en && live && is_sc)
                 || (load_en && live && dMemWEN && link_hit);

  llsc_link_reg u_link (
    .CLK       (CLK),
    .nRST      (nRST),
    .set_link  (set_link),
    .clr_link  (clr_link),
    .addr      (aluOutport[31:2]),
    .link_valid(link_valid),
    .link_hit  (link_hit)
  );
`else
  assign req = memop;
`endif

  assign active_req     = req && (state != DONE);
  assign mem_stall      = active_req && !dbus.dhit;
  assign load_en        = pipe_en && !mem_stall;

  assign dbus.dmemREN   = active_req && dMemREN;
  assign dbus.dmemWEN   = active_req && dMemWEN;
  assign dbus.dmemaddr  = nRST ? aluOutport : '0;
  assign dbus.dmemstore = nRST ? rdat2 : '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, WAIT: begin
        if (!active_req) begin
          state_nxt = IDLE;
        end else if (dbus.dhit) begin
          state_nxt = pipe_en ? IDLE : DONE;
        end else begin
          state_nxt = WAIT;
        end
      end
      DONE: begin
        if (pipe_en) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ldbuf <= '0;
    end else if (active_req && dbus.dhit && !pipe_en) begin
      ldbuf <= dbus.dmemload;
    end
  end

  assign ld_data = (state == DONE) ? ldbuf : dbus.dmemload;

  always_comb begin
    wsel_nxt = RegDst ? rd : rt;
    wdat_nxt = MemToReg ? ld_data : aluOutport;
    if (JType) begin
      wsel_nxt = LINK_REG;
      wdat_nxt = pcplus4;
    end
`ifdef MEM_LLSC_EN
    else if (is_sc) begin
      wdat_nxt = {31'd0, link_hit};
    end
`endif
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      memwb_valid  <= 1'b0;
      memwb_regWEN <= 1'b0;
      memwb_halt   <= 1'b0;
      memwb_wsel   <= '0;
      memwb_wdat   <= '0;
      halt         <= 1'b0;
    end else if (load_en) begin
      memwb_valid  <= live;
      memwb_regWEN <= live && regWEN;
      memwb_halt   <= live && Halt;
      memwb_wsel   <= wsel_nxt;
      memwb_wdat   <= wdat_nxt;
      if (live && Halt) begin
        halt <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  typedef struct packed {
    logic        valid;
    logic        wen;
    logic        hlt;
    logic [4:0]  wsel;
    logic [31:0] wdat;
  } exp_t;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        pipe_en;
  logic        exmem_valid;
  logic [31:0] aluOutport, rdat2, pcplus4;
  logic [4:0]  rt, rd;
  logic        MemToReg, JType, RegDst, regWEN, dMemREN, dMemWEN, Halt;
`ifdef MEM_LLSC_EN
  logic        is_ll, is_sc, link_inv;
`endif
  logic        mem_stall, memwb_valid, memwb_regWEN, memwb_halt, halt;
  logic [4:0]  memwb_wsel;
  logic [31:0] memwb_wdat;

  mem_stage_if dbus ();

  mem_stage dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .pipe_en     (pipe_en),
    .exmem_valid (exmem_valid),
    .aluOutport  (aluOutport),
    .rdat2       (rdat2),
    .pcplus4     (pcplus4),
    .rt          (rt),
    .rd          (rd),
    .MemToReg    (MemToReg),
    .JType       (JType),
    .RegDst      (RegDst),
    .regWEN      (regWEN),
    .dMemREN     (dMemREN),
    .dMemWEN     (dMemWEN),
    .Halt        (Halt),
`ifdef MEM_LLSC_EN
    .is_ll       (is_ll),
    .is_sc       (is_sc),
    .link_inv    (link_inv),
`endif
    .dbus        (dbus),
    .mem_stall   (mem_stall),
    .memwb_valid (memwb_valid),
    .memwb_regWEN(memwb_regWEN),
    .memwb_halt  (memwb_halt),
    .memwb_wsel  (memwb_wsel),
    .memwb_wdat  (memwb_wdat),
    .halt        (halt)
  );

  always #5 CLK = ~CLK;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic v, input logic w, input logic h, input logic [4:0] s, input logic [31:0] d);
    exp_t e;
    e.valid = v; e.wen = w; e.hlt = h; e.wsel = s; e.wdat = d;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    check({tag, "_pending"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_valid"}, 32'(memwb_valid), 32'(e.valid));
      check({tag, "_regwen"}, 32'(memwb_regWEN), 32'(e.wen));
      check({tag, "_halt"}, 32'(memwb_halt), 32'(e.hlt));
      if (e.valid) begin
        check({tag, "_wsel"}, 32'(memwb_wsel), 32'(e.wsel));
        check({tag, "_wdat"}, memwb_wdat, e.wdat);
      end
    end
  endtask

  task automatic clear_ex();
    exmem_valid = 0; aluOutport = 0; rdat2 = 0; pcplus4 = 0; rt = 0; rd = 0;
    MemToReg = 0; JType = 0; RegDst = 0; regWEN = 0; dMemREN = 0; dMemWEN = 0; Halt = 0;
`ifdef MEM_LLSC_EN
    is_ll = 0; is_sc = 0; link_inv = 0;
`endif
  endtask

  task automatic edge1();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_lw(input logic [31:0] a, input logic [4:0] t);
    clear_ex();
    exmem_valid = 1; aluOutport = a; rt = t; rd = 5'd1; MemToReg = 1; regWEN = 1; dMemREN = 1;
  endtask

  initial begin
    clear_ex();
    pipe_en = 1;
    dbus.dhit = 0;
    dbus.dmemload = 0;
    nRST = 0;
    aluOutport = 32'h100;
    rdat2 = 32'h55;
    #3;
    check("rst_addr", dbus.dmemaddr, 0);
    check("rst_store", dbus.dmemstore, 0);
    check("rst_ren", 32'(dbus.dmemREN), 0);
    check("rst_stall", 32'(mem_stall), 0);
    check("rst_valid", 32'(memwb_valid), 0);
    check("rst_wdat", memwb_wdat, 0);
    check("rst_halt", 32'(halt), 0);
    clear_ex();
    edge1();
    nRST = 1;
    edge1();

    // LW hit in the request cycle
    set_lw(32'h100, 5'd5);
    rd = 5'd9;
    dbus.dhit = 1; dbus.dmemload = 32'hDEADBEEF;
    push(1, 1, 0, 5'd5, 32'hDEADBEEF);
    #1;
    check("lw_ren", 32'(dbus.dmemREN), 1);
    check("lw_stall", 32'(mem_stall), 0);
    check("lw_addr", dbus.dmemaddr, 32'h100);
    edge1();
    pop_check("lw_hit");
    clear_ex();
    dbus.dhit = 0;
    #1;
    check("lw_ren_drop", 32'(dbus.dmemREN), 0);

    // SW with a 3-cycle miss
    clear_ex();
    exmem_valid = 1; aluOutport = 32'h40; rdat2 = 32'h1234; rt = 5'd4; dMemWEN = 1;
    push(1, 0, 0, 5'd4, 32'h40);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("sw_stall", 32'(mem_stall), 1);
      check("sw_wen", 32'(dbus.dmemWEN), 1);
      check("sw_addr", dbus.dmemaddr, 32'h40);
      check("sw_store", dbus.dmemstore, 32'h1234);
      edge1();
    end
    dbus.dhit = 1;
    #1;
    check("sw_hit_stall", 32'(mem_stall), 0);
    check("sw_hit_wen", 32'(dbus.dmemWEN), 1);
    edge1();
    pop_check("sw_miss");
    dbus.dhit = 0;

    // LW completing while frozen: data must come from the buffer
    set_lw(32'h200, 5'd7);
    dbus.dhit = 1; dbus.dmemload = 32'hCAFEF00D;
    pipe_en = 0;
    push(1, 1, 0, 5'd7, 32'hCAFEF00D);
    #1;
    check("frz_ren", 32'(dbus.dmemREN), 1);
    check("frz_stall", 32'(mem_stall), 0);
    edge1();
    dbus.dhit = 0; dbus.dmemload = 32'h11111111;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("frz_hold_ren", 32'(dbus.dmemREN), 0);
      check("frz_hold_stall", 32'(mem_stall), 0);
      check("frz_hold_wb", memwb_wdat, 32'h40);
      edge1();
    end
    pipe_en = 1;
    edge1();
    pop_check("lw_frozen");

    // JAL
    clear_ex();
    exmem_valid = 1; JType = 1; regWEN = 1; pcplus4 = 32'h204; rt = 5'd3; rd = 5'd6;
    aluOutport = 32'h999;
    push(1, 1, 0, 5'd31, 32'h204);
    #1;
    check("jal_ren", 32'(dbus.dmemREN), 0);
    check("jal_wen", 32'(dbus.dmemWEN), 0);
    edge1();
    pop_check("jal");

    // R-type with RegDst
    clear_ex();
    exmem_valid = 1; RegDst = 1; regWEN = 1; rd = 5'd12; rt = 5'd2; aluOutport = 32'hABCD0000;
    push(1, 1, 0, 5'd12, 32'hABCD0000);
    edge1();
    pop_check("rtype");

    // bubble with a stray dhit
    clear_ex();
    dMemREN = 1; regWEN = 1; aluOutport = 32'h300;
    dbus.dhit = 1;
    push(0, 0, 0, 5'd0, 32'h0);
    #1;
    check("bub_ren", 32'(dbus.dmemREN), 0);
    edge1();
    pop_check("bubble");
    dbus.dhit = 0;

    // Halt, then a load that must be squashed
    clear_ex();
    exmem_valid = 1; Halt = 1;
    push(1, 0, 1, 5'd0, 32'h0);
    edge1();
    pop_check("halt_instr");
    check("halt_set", 32'(halt), 1);
    set_lw(32'h100, 5'd8);
    push(0, 0, 0, 5'd0, 32'h0);
    #1;
    check("halt_ren", 32'(dbus.dmemREN), 0);
    check("halt_stall", 32'(mem_stall), 0);
    edge1();
    pop_check("halt_lw");
    check("halt_sticky", 32'(halt), 1);

    // reset in the middle of a miss
    clear_ex();
    nRST = 0;
    #1;
    nRST = 1;
    edge1();
    set_lw(32'h300, 5'd10);
    rdat2 = 32'h77;
    #1;
    check("rw_stall0", 32'(mem_stall), 1);
    edge1();
    check("rw_ren_wait", 32'(dbus.dmemREN), 1);
    nRST = 0;
    #1;
    check("rw_ren", 32'(dbus.dmemREN), 0);
    check("rw_stall", 32'(mem_stall), 0);
    check("rw_addr", dbus.dmemaddr, 0);
    check("rw_store", dbus.dmemstore, 0);
    check("rw_halt", 32'(halt), 0);
    check("rw_valid", 32'(memwb_valid), 0);
    clear_ex();
    edge1();
    nRST = 1;
    edge1();

`ifdef MEM_LLSC_EN
    // LL then SC to the same word: success
    set_lw(32'h80, 5'd11);
    is_ll = 1;
    dbus.dhit = 1; dbus.dmemload = 32'h5A5A;
    push(1, 1, 0, 5'd11, 32'h5A5A);
    edge1();
    pop_check("ll1");
    clear_ex();
    exmem_valid = 1; is_sc = 1; dMemWEN = 1; regWEN = 1; aluOutport = 32'h80; rt = 5'd3;
    push(1, 1, 0, 5'd3, 32'd1);
    #1;
    check("sc_ok_wen", 32'(dbus.dmemWEN), 1);
    edge1();
    pop_check("sc_ok");

    // LL, link_inv, SC: fails without touching the cache
    set_lw(32'h80, 5'd11);
    is_ll = 1;
    push(1, 1, 0, 5'd11, 32'h5A5A);
    edge1();
    pop_check("ll2");
    clear_ex();
    link_inv = 1;
    push(0, 0, 0, 5'd0, 32'h0);
    edge1();
    pop_check("inv_bubble");
    clear_ex();
    dbus.dhit = 0;
    exmem_valid = 1; is_sc = 1; dMemWEN = 1; regWEN = 1; aluOutport = 32'h80; rt = 5'd3;
    push(1, 1, 0, 5'd3, 32'd0);
    #1;
    check("sc_fail_wen", 32'(dbus.dmemWEN), 0);
    check("sc_fail_stall", 32'(mem_stall), 0);
    edge1();
    pop_check("sc_fail");
    clear_ex();
`endif

    check("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
